// File: rtl/matrix_writer.sv
// matrix_writer
//   Stores one matrix into a fixed-size slot of the shared matrix BRAM.
//   Slot layout (base = matrix_id * BLOCK_SIZE, truncated to ADDR_WIDTH):
//     base+0 = {rows, cols, 16'h0000}
//     base+1 = name[63:32]
//     base+2 = name[31:0]
//     base+3 + r*cols + c = element (r, c), row-major
//   The header is taken in the single start cycle and three metadata words
//   are written. Elements then arrive over a valid/ready stream, and each one
//   is written to BRAM in the cycle it is accepted.
//
// Optional feature macro: MATRIX_WRITER_BOUNDS_CHECK_EN
//   When defined, a start is rejected (error pulse, no writes) if the
//   element count does not fit the slot or the slot does not fit the BRAM.
//   When undefined, error is tied low and addresses wrap modulo 2**ADDR_WIDTH.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          request (sampled in IDLE) / return-to-IDLE
//   matrix_id, rows,      header, sampled with start
//   cols, name
//   data_in, data_valid   element stream in
//   data_ready            high in WR_DATA
//   busy, done, error     status (done/error are one-cycle pulses)
//   bram_we, bram_addr,   BRAM write port; addr/din are 0 outside writes
//   bram_din
module matrix_writer #(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2:0]            matrix_id,
  input  logic [7:0]            rows,
  input  logic [7:0]            cols,
  input  logic [63:0]           name,
  input  logic [31:0]           data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_din
);

  typedef enum logic [2:0] {
    IDLE,
    WR_META_0,
    WR_META_1,
    WR_META_2,
    WR_DATA,
    DONE_STATE,
    ERR_STATE
  } state_t;

  state_t                state, state_nxt;
  logic [2:0]            id_q;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [63:0]           name_q;
  logic [7:0]            row_cnt;
  logic [7:0]            col_cnt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           base_full;
  logic [ADDR_WIDTH-1:0] base;
  logic                  reject;
  logic                  col_last;
  logic                  row_last;

  // Slot base from the latched ID; the product is truncated to the BRAM width.
  assign base_full = 32'(id_q) * 32'(BLOCK_SIZE);
  assign base      = base_full[ADDR_WIDTH-1:0];

  assign col_last = (col_cnt == cols_q - 8'd1);
  assign row_last = (row_cnt == rows_q - 8'd1);

`ifdef MATRIX_WRITER_BOUNDS_CHECK_EN
  logic [15:0] req_elems;
  logic [63:0] req_end;

  // Checked against the live request inputs, since the decision is made
  // in the same cycle that start is sampled.
  assign req_elems = 16'(rows) * 16'(cols);
  assign req_end   = 64'(matrix_id) * 64'(BLOCK_SIZE) + 64'(BLOCK_SIZE);
  assign reject    = (32'(req_elems) > 32'(BLOCK_SIZE - 3)) ||
                     (req_end > (64'd1 << ADDR_WIDTH));
  assign error     = (state == ERR_STATE) && !abort;
`else
  assign reject    = 1'b0;
  assign error     = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    data_ready = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_din   = '0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = reject ? ERR_STATE : WR_META_0;
      end
      WR_META_0: begin
        bram_we   = 1'b1;
        bram_addr = base;
        bram_din  = {rows_q, cols_q, 16'h0000};
        state_nxt = WR_META_1;
      end
      WR_META_1: begin
        bram_we   = 1'b1;
        bram_addr = base + ADDR_WIDTH'(1);
        bram_din  = name_q[63:32];
        state_nxt = WR_META_2;
      end
      WR_META_2: begin
        bram_we   = 1'b1;
        bram_addr = base + ADDR_WIDTH'(2);
        bram_din  = name_q[31:0];
        // Empty matrices still get a header but accept no elements.
        state_nxt = (rows_q == 8'd0 || cols_q == 8'd0) ? DONE_STATE : WR_DATA;
      end
      WR_DATA: begin
        data_ready = 1'b1;
        if (data_valid) begin
          bram_we   = 1'b1;
          bram_addr = cur_addr;
          bram_din  = data_in;
          if (row_last && col_last) state_nxt = DONE_STATE;
        end
      end
      DONE_STATE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR_STATE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Abort wins over everything: no write and no pulse this cycle.
    if (abort) begin
      state_nxt = IDLE;
      bram_we   = 1'b0;
      bram_addr = '0;
      bram_din  = '0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      id_q     <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      name_q   <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      cur_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        id_q   <= matrix_id;
        rows_q <= rows;
        cols_q <= cols;
        name_q <= name;
      end
      if (state == WR_META_2) begin
        row_cnt  <= '0;
        col_cnt  <= '0;
        cur_addr <= base + ADDR_WIDTH'(3);
      end
      if (state == WR_DATA && data_valid && !abort) begin
        cur_addr <= cur_addr + ADDR_WIDTH'(1);
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 8'd1;
        end else begin
          col_cnt <= col_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_writer.sv
// tb_matrix_writer
//   Directed bench for matrix_writer. A negedge monitor logs every BRAM
//   write (address, data, cycle), every done/error pulse and every
//   data_ready cycle; each scenario clears the log, runs, and compares the
//   log against hand-computed expectations.
`timescale 1ns/1ps
module tb_matrix_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  matrix_id = '0;
  logic [7:0]  rows = '0;
  logic [7:0]  cols = '0;
  logic [63:0] name = '0;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready, busy, done, error, bram_we;
  logic [13:0] bram_addr;
  logic [31:0] bram_din;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          done_c[$];
  int          err_c[$];
  int          rdy_n = 0;
  int          t, s;
  logic [31:0] exp1[9];

  matrix_writer #(.BLOCK_SIZE(1152), .ADDR_WIDTH(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .matrix_id(matrix_id), .rows(rows), .cols(cols), .name(name),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done), .error(error),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_we) begin
        wa.push_back(int'(bram_addr));
        wd.push_back(bram_din);
        wc.push_back(cyc);
      end
      if (done)       done_c.push_back(cyc);
      if (error)      err_c.push_back(cyc);
      if (data_ready) rdy_n = rdy_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
    done_c.delete(); err_c.delete();
    rdy_n = 0;
  endtask

  // Drives start for one cycle; t returns the cycle index of the start cycle.
  task automatic do_start(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                          input logic [63:0] nm, output int tt);
    @(posedge clk); #1;
    start = 1'b1; matrix_id = id; rows = r; cols = c; name = nm;
    tt = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams n elements (values dbase, dbase+1, ...); toggle=1 gaps data_valid.
  task automatic stream(input int n, input bit toggle, input logic [31:0] dbase, output int sent);
    bit ph;
    bit prev_rdy;
    ph = 1'b1;
    prev_rdy = 1'b0;
    sent = 0;
    for (int g = 0; g < 100; g++) begin
      @(posedge clk); #1;
      if (data_valid && prev_rdy) sent = sent + 1;
      if (sent >= n) break;
      data_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      data_in = dbase + 32'(sent);
      prev_rdy = data_ready;
    end
    data_valid = 1'b0;
    data_in = '0;
    if (sent < n) check("stream_timeout", 64'(sent), 64'(n));
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 50; g++) begin
      @(posedge clk); #1;
      if (!busy) return;
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_ready", {63'd0, data_ready}, 64'd0);
    check("rst_we",    {63'd0, bram_we}, 64'd0);
    check("rst_addr",  64'(bram_addr), 64'd0);
    check("rst_din",   64'(bram_din), 64'd0);
    check("rst_done",  {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    rst_n = 1'b1;

    // id=1, 2x3 "MATRIX_A", elements 1..6 with data_valid held high
    clear_log();
    exp1 = '{32'h02030000, 32'h4D415452, 32'h49585F41, 1, 2, 3, 4, 5, 6};
    do_start(3'd1, 8'd2, 8'd3, 64'h4D415452_49585F41, t);
    stream(6, 1'b0, 32'd1, s);
    wait_idle();
    check("t1_nwr", 64'(wa.size()), 64'd9);
    for (int i = 0; i < 9 && i < wa.size(); i++) begin
      check($sformatf("t1_addr%0d", i), 64'(wa[i]), 64'(1152 + i));
      check($sformatf("t1_data%0d", i), 64'(wd[i]), 64'(exp1[i]));
      check($sformatf("t1_cyc%0d", i),  64'(wc[i]), 64'(t + 1 + i));
    end
    check("t1_done_n", 64'(done_c.size()), 64'd1);
    if (done_c.size() > 0) check("t1_done_cyc", 64'(done_c[0]), 64'(t + 10));

    // id=0, 3x3, data_valid toggling
    clear_log();
    do_start(3'd0, 8'd3, 8'd3, 64'h41424344_45464748, t);
    stream(9, 1'b1, 32'hA0, s);
    wait_idle();
    check("t2_nwr", 64'(wa.size()), 64'd12);
    if (wa.size() == 12) begin
      check("t2_meta0", 64'(wd[0]), 64'h03030000);
      check("t2_meta2", 64'(wd[2]), 64'h45464748);
      for (int i = 3; i < 12; i++) begin
        check($sformatf("t2_addr%0d", i), 64'(wa[i]), 64'(i));
        check($sformatf("t2_data%0d", i), 64'(wd[i]), 64'(32'hA0 + 32'(i - 3)));
        if (i > 3) check($sformatf("t2_gap%0d", i), 64'(wc[i] - wc[i-1]), 64'd2);
      end
      if (done_c.size() > 0) check("t2_done_cyc", 64'(done_c[0]), 64'(wc[11] + 1));
    end
    check("t2_done_n", 64'(done_c.size()), 64'd1);

    // id=2, rows=0, cols=5: header only
    clear_log();
    do_start(3'd2, 8'd0, 8'd5, 64'h5A45524F_524F5753, t);
    wait_idle();
    check("t3_nwr", 64'(wa.size()), 64'd3);
    if (wa.size() == 3) begin
      check("t3_addr0", 64'(wa[0]), 64'd2304);
      check("t3_data0", 64'(wd[0]), 64'h00050000);
      check("t3_data1", 64'(wd[1]), 64'h5A45524F);
      check("t3_addr2", 64'(wa[2]), 64'd2306);
    end
    check("t3_ready_n", 64'(rdy_n), 64'd0);
    check("t3_done_n", 64'(done_c.size()), 64'd1);
    if (done_c.size() > 0) check("t3_done_cyc", 64'(done_c[0]), 64'(t + 4));

    // Abort after 4 of 6 elements, then a fresh 1x1 store
    clear_log();
    do_start(3'd3, 8'd2, 8'd3, 64'h41424F52_54544553, t);
    stream(4, 1'b0, 32'h10, s);
    abort = 1'b1; data_valid = 1'b1; data_in = 32'hDEAD;
    @(posedge clk); #1;
    abort = 1'b0; data_valid = 1'b0; data_in = '0;
    check("t4_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_nwr", 64'(wa.size()), 64'd7);
    if (wa.size() == 7) check("t4_last_addr", 64'(wa[6]), 64'd3462);
    check("t4_done_n", 64'(done_c.size()), 64'd0);
    clear_log();
    do_start(3'd4, 8'd1, 8'd1, 64'h4E455854_4F4E4531, t);
    stream(1, 1'b0, 32'h77, s);
    wait_idle();
    check("t4b_nwr", 64'(wa.size()), 64'd4);
    if (wa.size() == 4) begin
      check("t4b_addr3", 64'(wa[3]), 64'd4611);
      check("t4b_data3", 64'(wd[3]), 64'h77);
    end
    check("t4b_done_n", 64'(done_c.size()), 64'd1);

`ifdef MATRIX_WRITER_BOUNDS_CHECK_EN
    // 40x40 = 1600 elements exceeds the 1149-word payload: rejected
    clear_log();
    do_start(3'd5, 8'd40, 8'd40, 64'h42494742_49474249, t);
    repeat (3) @(posedge clk);
    #1;
    check("t5_err_n", 64'(err_c.size()), 64'd1);
    if (err_c.size() > 0) check("t5_err_cyc", 64'(err_c[0]), 64'(t + 1));
    check("t5_nwr", 64'(wa.size()), 64'd0);
    check("t5_busy", {63'd0, busy}, 64'd0);
`else
    check("t5_no_err", 64'(err_c.size()), 64'd0);
`endif

    // Reset during WR_DATA, then start-while-busy is ignored
    clear_log();
    do_start(3'd5, 8'd2, 8'd2, 64'h52455345_54544553, t);
    stream(2, 1'b0, 32'h50, s);
    data_valid = 1'b1; data_in = 32'h99;
    rst_n = 1'b0;
    #1;
    check("t6_busy",  {63'd0, busy}, 64'd0);
    check("t6_ready", {63'd0, data_ready}, 64'd0);
    check("t6_we",    {63'd0, bram_we}, 64'd0);
    check("t6_addr",  64'(bram_addr), 64'd0);
    check("t6_din",   64'(bram_din), 64'd0);
    @(posedge clk); #1;
    data_valid = 1'b0; data_in = '0;
    rst_n = 1'b1;
    clear_log();
    do_start(3'd6, 8'd1, 8'd1, 64'h4F4E4345_4F4E4C59, t);
    start = 1'b1; matrix_id = 3'd1; rows = 8'd2; cols = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    stream(1, 1'b0, 32'h66, s);
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    check("t6_nwr", 64'(wa.size()), 64'd4);
    if (wa.size() == 4) begin
      check("t6_addr0", 64'(wa[0]), 64'd6912);
      check("t6_meta0", 64'(wd[0]), 64'h01010000);
      check("t6_addr3", 64'(wa[3]), 64'd6915);
      check("t6_data3", 64'(wd[3]), 64'h66);
    end
    check("t6_done_n", 64'(done_c.size()), 64'd1);
    check("t6_idle", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
